// File: rtl/bus_bridge_master.sv
// bus_bridge_master: master side of the UART bus bridge.
//   A 21-bit UART command frame {addr, data, mode} (LSB first) starts one
//   bit-serial bus transaction. Writes send address then data; reads send
//   address, capture DATA_WIDTH returned bits and send the byte back on u_tx.
// Ports:
//   clk, rstn           clock; synchronous active-high reset (rstn=1 resets)
//   mwdata/mmode/mvalid serial address/write data, mode, bit qualifier
//   mrdata/svalid       serial read data from slave and its qualifier
//   mbreq/mbgrant       bus request / grant
//   msplit, ack         slave split and address acknowledge
//   u_rx, u_tx          UART lines, idle high
// Build option: define BB_MASTER_WRITE_ECHO_EN to echo written data on u_tx.
module bus_bridge_master #(
  parameter int ADDR_WIDTH            = 16,
  parameter int DATA_WIDTH            = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH  = 12,
  parameter int BB_ADDR_WIDTH         = 12,
  parameter int UART_CLOCKS_PER_PULSE = 5208,
  parameter int ACK_TIMEOUT           = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic mrdata,
  output logic mwdata,
  output logic mmode,
  output logic mvalid,
  input  logic svalid,
  output logic mbreq,
  input  logic mbgrant,
  input  logic msplit,
  input  logic ack,
  output logic u_tx,
  input  logic u_rx
);

  localparam int FRAME_W = BB_ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int UCW     = $clog2(UART_CLOCKS_PER_PULSE + 1);
  localparam int FBW     = $clog2(FRAME_W + 1);
  localparam int BMAX    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BCW     = $clog2(BMAX + 1);
  localparam int TOW     = $clog2(ACK_TIMEOUT + 1);
  localparam int TXW     = DATA_WIDTH + 2;
  localparam int TBW     = $clog2(TXW + 1);

  localparam logic [UCW-1:0] BIT_LAST  = UCW'(UART_CLOCKS_PER_PULSE - 1);
  localparam logic [UCW-1:0] HALF_LAST = UCW'(UART_CLOCKS_PER_PULSE / 2 - 1);

  if (BB_ADDR_WIDTH > ADDR_WIDTH || SLAVE_MEM_ADDR_WIDTH > ADDR_WIDTH) begin : g_bad_params
    $error("bus_bridge_master: address widths exceed ADDR_WIDTH");
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [3:0] {S_IDLE, S_REQ, S_ADDR, S_WAIT_ACK, S_WDATA, S_RDATA,
                            S_TXSTART, S_TXWAIT, S_DONE} state_t;

  rx_state_t            rx_state_q, rx_state_d;
  logic [UCW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [FBW-1:0]       rx_bit_q, rx_bit_d;
  logic [FRAME_W-1:0]   rx_shift_q, rx_shift_d;
  logic                 rx_valid_q, rx_valid_d;

  state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                 mode_q, mode_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TOW-1:0]       to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;

  logic                 tx_busy_q, tx_busy_d;
  logic [TXW-1:0]       tx_shift_q, tx_shift_d;
  logic [UCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [TBW-1:0]       tx_bit_q, tx_bit_d;

  logic                 tx_load;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                 bus_ok;

  // UART receiver
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!u_rx) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // a start bit that is high again at mid-bit was a glitch
          rx_state_d = u_rx ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {u_rx, rx_shift_q[FRAME_W-1:1]};
          if (rx_bit_q == FBW'(FRAME_W - 1)) rx_state_d = RX_STOP;
          else                               rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_valid_d = u_rx;
          rx_state_d = RX_WAIT_HIGH;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      // after a bad stop bit the line may still be low; never treat it as a start
      RX_WAIT_HIGH: if (u_rx) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Bus master FSM
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    rd_d      = rd_q;
    mwdata    = 1'b0;
    mmode     = 1'b0;
    mvalid    = 1'b0;
    mbreq     = 1'b0;
    tx_load   = 1'b0;
    tx_byte   = rd_q;
    bus_ok    = mbgrant & ~msplit;
    case (state_q)
      S_IDLE: begin
        if (rx_valid_q) begin
          addr_d    = ADDR_WIDTH'(rx_shift_q[FRAME_W-1 -: BB_ADDR_WIDTH]);
          data_d    = rx_shift_q[DATA_WIDTH:1];
          mode_d    = rx_shift_q[0];
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        mbreq = 1'b1;
        if (mbgrant) state_d = S_ADDR;
      end
      // address and data registers rotate, so they return to their
      // original value once a full field has been sent
      S_ADDR: begin
        mbreq = 1'b1;
        if (bus_ok) begin
          mvalid = 1'b1;
          mmode  = mode_q;
          mwdata = addr_q[0];
          addr_d = {addr_q[0], addr_q[ADDR_WIDTH-1:1]};
          if (bit_cnt_q == BCW'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = S_WAIT_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        mbreq = 1'b1;
        if (ack)                                 state_d  = mode_q ? S_WDATA : S_RDATA;
        else if (to_cnt_q == TOW'(ACK_TIMEOUT - 1)) state_d = S_IDLE;
        else                                     to_cnt_d = to_cnt_q + 1'b1;
      end
      S_WDATA: begin
        mbreq = 1'b1;
        if (bus_ok) begin
          mvalid = 1'b1;
          mmode  = 1'b1;
          mwdata = data_q[0];
          data_d = {data_q[0], data_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_RDATA: begin
        mbreq = 1'b1;
        if (bus_ok && svalid) begin
          rd_d = {mrdata, rd_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_TXSTART;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_TXSTART: begin
        tx_load = 1'b1;
        tx_byte = rd_q;
        state_d = S_TXWAIT;
      end
      S_TXWAIT: if (!tx_busy_q) state_d = S_IDLE;
      S_DONE: begin
`ifdef BB_MASTER_WRITE_ECHO_EN
        tx_load = 1'b1;
        tx_byte = data_q;
        state_d = S_TXWAIT;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // UART transmitter: {stop, payload, start} shifted out LSB first
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    if (tx_load) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[TXW-1:1]};
        if (tx_bit_q == TBW'(TXW - 1)) tx_busy_d = 1'b0;
        else                           tx_bit_d  = tx_bit_q + 1'b1;
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  assign u_tx = tx_busy_q ? tx_shift_q[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      rd_q       <= '0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      rd_q       <= rd_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

endmodule

// File: tb/tb_bus_bridge_master.sv
module tb_bus_bridge_master;
  localparam int CPP = 8;
  localparam int ACK_TO = 16;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int W = 240;

  logic clk = 1'b0;
  logic rstn, mrdata, mwdata, mmode, mvalid, svalid, mbreq, mbgrant, msplit, ack, u_tx, u_rx;
  int checks = 0;
  int errors = 0;

  bus_bridge_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SLAVE_MEM_ADDR_WIDTH(12),
    .BB_ADDR_WIDTH(12),
    .UART_CLOCKS_PER_PULSE(CPP),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .rstn(rstn), .mrdata(mrdata), .mwdata(mwdata), .mmode(mmode),
    .mvalid(mvalid), .svalid(svalid), .mbreq(mbreq), .mbgrant(mbgrant),
    .msplit(msplit), .ack(ack), .u_tx(u_tx), .u_rx(u_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        mode;
    logic        stop;
    logic        ack_en;
    logic        rd_bit;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    int          exp_wbits;
    int          exp_wait;
    logic        exp_tx;
    logic [7:0]  exp_tx_byte;
    int          exp_low;
  } vec_t;

  vec_t vecs[6];

  // transaction observations
  logic        r_req;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  int          r_acnt, r_dcnt, r_wait, r_mode_err, r_split_obs, r_split_err, r_low;
  logic        r_tx_found;
  logic [9:0]  r_tx_frame;
  logic        hist[W];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [11:0] a, input logic [7:0] d, input logic m, input logic stop);
    logic [20:0] f;
    f = {a, d, m};
    @(negedge clk);
    u_rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      u_rx = f[i];
      repeat (CPP) @(negedge clk);
    end
    u_rx = stop;
    if (!stop) begin
      repeat (CPP) @(negedge clk);
      u_rx = 1'b1;
    end
  endtask

  // Slave/arbiter model: grants whenever requested, acks once the full
  // address has been seen, streams rd_bit as read data, optional split.
  task automatic run_txn(input logic exp_mode, input logic ack_en, input logic rd_bit,
                         input int split_after, input int split_len);
    int split_left;
    int first;
    int idx;
    split_left = split_len;
    r_req = 1'b0; r_addr = '0; r_data = '0; r_acnt = 0; r_dcnt = 0; r_wait = 0;
    r_mode_err = 0; r_split_obs = 0; r_split_err = 0; r_low = 0;
    r_tx_found = 1'b0; r_tx_frame = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (mbreq) r_req = 1'b1;
      if (msplit) begin
        r_split_obs++;
        if (mvalid) r_split_err++;
      end
      if (mvalid) begin
        if (mmode !== exp_mode) r_mode_err++;
        if (r_acnt < AW) begin
          r_addr = {mwdata, r_addr[15:1]};
          r_acnt++;
        end else begin
          if (r_dcnt < DW) r_data = {mwdata, r_data[7:1]};
          r_dcnt++;
        end
      end else if (mbreq && r_acnt == AW) begin
        r_wait++;
      end
      hist[i] = u_tx;
      mbgrant = mbreq;
      ack     = ack_en && mbreq && (r_acnt == AW);
      svalid  = ack && !exp_mode;
      mrdata  = rd_bit;
      if (split_len > 0 && r_acnt == split_after && split_left > 0) begin
        msplit = 1'b1;
        split_left--;
      end else begin
        msplit = 1'b0;
      end
    end
    mbgrant = 1'b0; ack = 1'b0; svalid = 1'b0; mrdata = 1'b0; msplit = 1'b0;
    first = -1;
    for (int i = 0; i < W; i++) if (first < 0 && hist[i] == 1'b0) first = i;
    if (first >= 0) begin
      r_tx_found = 1'b1;
      for (int b = 0; b < 10; b++) begin
        idx = first + CPP / 2 + b * CPP;
        r_tx_frame = {(idx < W) ? hist[idx] : 1'bx, r_tx_frame[9:1]};
      end
      for (int k = first; k < W && hist[k] == 1'b0; k++) r_low++;
    end
  endtask

  initial begin
    int act;
    int seen;
    rstn = 1'b1; u_rx = 1'b1; mrdata = 1'b0; svalid = 1'b0;
    mbgrant = 1'b0; msplit = 1'b0; ack = 1'b0;

    //                addr    data   m  stp ack rd  req addr      wdata  wb wait tx    txbyte low
    vecs[0] = '{12'h123, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0123, 8'hAA, 8, 1,  1'b0, 8'h00, 0};
    vecs[1] = '{12'h055, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0055, 8'h00, 0, 9,  1'b1, 8'hFF, CPP};
    vecs[2] = '{12'h3C5, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h03C5, 8'h00, 0, ACK_TO, 1'b0, 8'h00, 0};
    vecs[3] = '{12'hFFF, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0FFF, 8'h81, 8, 1,  1'b0, 8'h00, 0};
    vecs[4] = '{12'h234, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 0, 0,  1'b0, 8'h00, 0};
    vecs[5] = '{12'h800, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0800, 8'h00, 0, 9,  1'b1, 8'h00, 9*CPP};
`ifdef BB_MASTER_WRITE_ECHO_EN
    vecs[0].exp_tx = 1'b1; vecs[0].exp_tx_byte = 8'hAA; vecs[0].exp_low = 2*CPP;
    vecs[3].exp_tx = 1'b1; vecs[3].exp_tx_byte = 8'h81; vecs[3].exp_low = CPP;
`endif

    // reset state
    repeat (10) @(negedge clk);
    check("reset mbreq", mbreq, 0);
    check("reset mvalid", mvalid, 0);
    check("reset u_tx", u_tx, 1);
    check("reset mwdata", mwdata, 0);
    check("reset mmode", mmode, 0);
    rstn = 1'b0;
    act = 0;
    repeat (30) begin
      @(negedge clk);
      if (mbreq || mvalid || !u_tx) act++;
    end
    check("idle activity", act, 0);

    // table-driven transactions
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].addr, vecs[v].data, vecs[v].mode, vecs[v].stop);
      run_txn(vecs[v].mode, vecs[v].ack_en, vecs[v].rd_bit, 0, 0);
      check($sformatf("row%0d mbreq_seen", v), r_req, vecs[v].exp_req);
      check($sformatf("row%0d addr_bits", v), r_acnt, vecs[v].exp_req ? AW : 0);
      if (vecs[v].exp_req) begin
        check($sformatf("row%0d addr", v), r_addr, vecs[v].exp_addr);
        check($sformatf("row%0d mmode_err", v), r_mode_err, 0);
        check($sformatf("row%0d data_bits", v), r_dcnt, vecs[v].exp_wbits);
        if (vecs[v].exp_wbits > 0) check($sformatf("row%0d wdata", v), r_data, vecs[v].exp_wdata);
        check($sformatf("row%0d wait_cycles", v), r_wait, vecs[v].exp_wait);
      end
      check($sformatf("row%0d tx_seen", v), r_tx_found, vecs[v].exp_tx);
      if (vecs[v].exp_tx && r_tx_found) begin
        check($sformatf("row%0d tx_frame", v), r_tx_frame, {1'b1, vecs[v].exp_tx_byte, 1'b0});
        check($sformatf("row%0d tx_low_len", v), r_low, vecs[v].exp_low);
      end
    end

    // split for 5 cycles after 6 address bits
    send_frame(12'h123, 8'hAA, 1'b1, 1'b1);
    run_txn(1'b1, 1'b1, 1'b0, 6, 5);
    check("split cycles", r_split_obs, 5);
    check("split mvalid", r_split_err, 0);
    check("split addr_bits", r_acnt, AW);
    check("split addr", r_addr, 16'h0123);
    check("split wdata", r_data, 8'hAA);
    check("split data_bits", r_dcnt, DW);

    // reset in the middle of the address phase
    send_frame(12'h0F0, 8'h3C, 1'b1, 1'b1);
    seen = 0;
    for (int i = 0; i < 100 && seen < 3; i++) begin
      @(negedge clk);
      if (mvalid) seen++;
      mbgrant = mbreq;
    end
    check("midrst reached addr", seen, 3);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst mbreq", mbreq, 0);
    check("midrst mvalid", mvalid, 0);
    check("midrst u_tx", u_tx, 1);
    mbgrant = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    send_frame(12'h055, 8'h00, 1'b0, 1'b1);
    run_txn(1'b0, 1'b1, 1'b1, 0, 0);
    check("post_rst addr", r_addr, 16'h0055);
    check("post_rst tx_seen", r_tx_found, 1);
    check("post_rst tx_frame", r_tx_frame, 10'h3FE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
